// File: rtl/spi_pkg.sv
// spi_pkg: shared state encoding, word width and bit-mask helper for the SPI sequencer
package spi_pkg;
    localparam int SPI_WMAX = 32;

    typedef enum logic [2:0] {IDLE, SETUP, LAUNCH, ARM, WAIT, STORE, DRAIN, HOLD} state_t;

    function automatic logic [SPI_WMAX-1:0] bits_mask(input logic [5:0] bits);
        return (bits == 6'd0 || bits >= 6'(SPI_WMAX)) ? '1 : (SPI_WMAX'(1) << bits) - SPI_WMAX'(1);
    endfunction
endpackage

// File: rtl/spi_sync_fifo.sv
// spi_sync_fifo: first-word-fall-through FIFO with wrap-bit pointers; head reads 0 while empty
module spi_sync_fifo #(
    parameter int W     = 32,
    parameter int DEPTH = 8
) (
    input  logic         clk,
    input  logic         resetb,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wptr, rptr;
    logic         do_push, do_pop;

    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign empty   = wptr == rptr;
    assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign dout    = empty ? '0 : mem[rptr[AW-1:0]];

    always_ff @(posedge clk or negedge resetb)
        if (!resetb) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            wptr <= wptr + {{AW{1'b0}}, do_push};
            rptr <= rptr + {{AW{1'b0}}, do_pop};
        end

    always_ff @(posedge clk)
        if (do_push) mem[wptr[AW-1:0]] <= din;
endmodule

// File: rtl/spi_fifo_seq.sv
// spi_fifo_seq: TX/RX FIFO sequencer driving a single-mode SPI master with cs_n setup/hold timing.
// Define SPI_RX_OVERRUN_EN to drop words on RX full (sticky rx_overrun, cleared by ovr_clr) instead of stalling.
module spi_fifo_seq
    import spi_pkg::*;
#(
    parameter int DEPTH    = 8,
    parameter int CS_SETUP = 2,
    parameter int CS_HOLD  = 2
) (
    input  logic                clk,
    input  logic                resetb,
    input  logic                tx_wr,
    input  logic [SPI_WMAX-1:0] tx_data,
    output logic                tx_full,
    input  logic                rx_rd,
    output logic [SPI_WMAX-1:0] rx_data,
    output logic                rx_empty,
    input  logic [5:0]          cfg_bits,
    input  logic [7:0]          cfg_div,
    input  logic                frame_end,
    output logic                cs_n,
    output logic                seq_busy,
    output logic                spi_wr,
    output logic [SPI_WMAX-1:0] spi_din,
    output logic [5:0]          spi_bits,
    output logic [7:0]          spi_div,
    input  logic                spi_busy,
    input  logic [SPI_WMAX-1:0] spi_dout
`ifdef SPI_RX_OVERRUN_EN
    ,
    output logic                rx_overrun,
    input  logic                ovr_clr
`endif
);
    state_t              state;
    logic [7:0]          cnt;
    logic                frame_pend;
    logic                tx_empty, rx_full, launch, rx_push;
    logic [SPI_WMAX-1:0] tx_head, rx_din;

`ifdef SPI_RX_OVERRUN_EN
    assign launch = state == LAUNCH;
`else
    assign launch = (state == LAUNCH) && !rx_full;
`endif
    assign rx_push  = state == STORE;
    assign rx_din   = spi_dout & bits_mask(spi_bits);
    assign seq_busy = (state != IDLE) || !tx_empty;

    spi_sync_fifo #(.W(SPI_WMAX), .DEPTH(DEPTH)) u_tx (
        .clk(clk), .resetb(resetb), .push(tx_wr), .din(tx_data), .pop(launch),
        .dout(tx_head), .full(tx_full), .empty(tx_empty)
    );

    spi_sync_fifo #(.W(SPI_WMAX), .DEPTH(DEPTH)) u_rx (
        .clk(clk), .resetb(resetb), .push(rx_push), .din(rx_din), .pop(rx_rd),
        .dout(rx_data), .full(rx_full), .empty(rx_empty)
    );

    // SETUP spans CS_SETUP-1 cycles and HOLD spans CS_HOLD cycles so cs_n brackets the word by exactly those counts
    always_ff @(posedge clk or negedge resetb)
        if (!resetb) begin
            state      <= IDLE;
            cnt        <= '0;
            cs_n       <= 1'b1;
            spi_wr     <= 1'b0;
            spi_din    <= '0;
            spi_bits   <= 6'd1;
            spi_div    <= '0;
            frame_pend <= 1'b0;
        end else begin
            spi_wr <= launch;
            if (frame_end && !(state == IDLE && cs_n)) frame_pend <= 1'b1;
            case (state)
                IDLE: if (!tx_empty) begin
                    cs_n  <= 1'b0;
                    cnt   <= 8'(CS_SETUP - 2);
                    state <= (CS_SETUP == 1) ? LAUNCH : SETUP;
                end
                SETUP: begin
                    cnt <= cnt - 8'd1;
                    if (cnt == 8'd0) state <= LAUNCH;
                end
                LAUNCH: if (launch) begin
                    spi_din  <= tx_head;
                    spi_bits <= (cfg_bits == 6'd0) ? 6'(SPI_WMAX) : cfg_bits;
                    spi_div  <= cfg_div;
                    state    <= ARM;
                end
                ARM: state <= WAIT;
                WAIT: if (!spi_busy) state <= STORE;
                STORE, DRAIN:
                    if (!tx_empty) state <= LAUNCH;
                    else if (frame_pend) begin
                        state      <= HOLD;
                        cnt        <= 8'(CS_HOLD - 1);
                        frame_pend <= 1'b0;
                    end else state <= DRAIN;
                HOLD: begin
                    cnt <= cnt - 8'd1;
                    if (cnt == 8'd0) begin
                        cs_n  <= 1'b1;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end

`ifdef SPI_RX_OVERRUN_EN
    always_ff @(posedge clk or negedge resetb)
        if (!resetb) rx_overrun <= 1'b0;
        else rx_overrun <= (rx_push && rx_full) || (rx_overrun && !ovr_clr);
`endif
endmodule

// File: tb/tb_spi_fifo_seq.sv
// tb_spi_fifo_seq: directed and randomized checks of spi_fifo_seq against a queue model and a simple SPI responder
module tb_spi_fifo_seq;
    localparam int DEPTH    = 8;
    localparam int CS_SETUP = 2;
    localparam int CS_HOLD  = 2;

    logic        clk = 0, resetb = 0, tx_wr = 0, rx_rd = 0, frame_end = 0, spi_busy = 0;
    logic [31:0] tx_data = 0, spi_dout = 0;
    logic [5:0]  cfg_bits = 6'd8;
    logic [7:0]  cfg_div = 8'd1;
    logic        tx_full, rx_empty, cs_n, seq_busy, spi_wr;
    logic [31:0] rx_data, spi_din;
    logic [5:0]  spi_bits;
    logic [7:0]  spi_div;
`ifdef SPI_RX_OVERRUN_EN
    logic        ovr_clr = 0, rx_overrun;
`endif

    int          n_chk = 0, n_fail = 0, wr_count = 0, wr_bad = 0, cs_rise = 0;
    logic        prev_cs = 1'b1;
    logic        use_ovr = 1'b0;
    logic [31:0] ovr_val = 0;
    logic [31:0] exp_q[$];

    spi_fifo_seq #(.DEPTH(DEPTH), .CS_SETUP(CS_SETUP), .CS_HOLD(CS_HOLD)) dut (
        .clk(clk), .resetb(resetb), .tx_wr(tx_wr), .tx_data(tx_data), .tx_full(tx_full),
        .rx_rd(rx_rd), .rx_data(rx_data), .rx_empty(rx_empty), .cfg_bits(cfg_bits),
        .cfg_div(cfg_div), .frame_end(frame_end), .cs_n(cs_n), .seq_busy(seq_busy),
        .spi_wr(spi_wr), .spi_din(spi_din), .spi_bits(spi_bits), .spi_div(spi_div),
        .spi_busy(spi_busy), .spi_dout(spi_dout)
`ifdef SPI_RX_OVERRUN_EN
        , .rx_overrun(rx_overrun), .ovr_clr(ovr_clr)
`endif
    );

    always #5 clk = ~clk;

    // Received word keeps only the low w bits (w=0 means a full 32-bit word)
    function automatic logic [31:0] model_mask(input logic [31:0] v, input int w);
        int e;
        e = (w == 0) ? 32 : w;
        return 32'(64'(v) % (64'd1 << e));
    endfunction

    // SPI master stand-in: busy one clk after wr, random duration, then loopback or a forced reply
    initial begin : responder
        logic [31:0] cap;
        forever begin
            @(negedge clk);
            if (spi_wr === 1'b1) begin
                cap = spi_din;
                @(posedge clk);
                #1 spi_busy = 1'b1;
                repeat ($urandom_range(1, 5)) @(posedge clk);
                #1 spi_busy = 1'b0;
                spi_dout = use_ovr ? ovr_val : cap;
            end
        end
    end

    always @(negedge clk) begin
        if (cs_n && !prev_cs) cs_rise++;
        prev_cs = cs_n;
        if (spi_wr) begin
            wr_count++;
            if (cs_n) wr_bad++;
        end
    end

    initial begin
        #2_000_000;
        $fatal(1, "FAIL watchdog: simulation did not finish");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [31:0] w, input bit acc);
        tx_data = w;
        tx_wr   = 1'b1;
        @(negedge clk);
        tx_wr = 1'b0;
        if (acc) exp_q.push_back(model_mask(use_ovr ? ovr_val : w, int'(cfg_bits)));
    endtask

    task automatic pulse_frame_end();
        frame_end = 1'b1;
        @(negedge clk);
        frame_end = 1'b0;
    endtask

    task automatic wait_cs(input logic v, input string tag);
        int n;
        n = 0;
        while (cs_n !== v && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk(tag, 32'(cs_n), 32'(v));
    endtask

    task automatic pop_check(input string tag);
        int n;
        logic [31:0] e;
        n = 0;
        while (rx_empty && n < 400) begin
            @(negedge clk);
            n++;
        end
        e = 32'hFFFF_FFFF;
        if (exp_q.size() > 0) e = exp_q.pop_front();
        chk(tag, rx_data, e);
        rx_rd = 1'b1;
        @(negedge clk);
        rx_rd = 1'b0;
    endtask

    task automatic wait_wr(input int target, input int base);
        int n;
        n = 0;
        #1;
        while ((wr_count - base) < target && n < 600) begin
            @(negedge clk);
            #1;
            n++;
        end
    endtask

    task automatic lat_test(input string tag, input logic [31:0] w);
        int cs_at, wr_at;
        cs_at = -1;
        wr_at = -1;
        push(w, 1'b1);
        for (int i = 1; i <= 12 && wr_at < 0; i++) begin
            if (cs_at < 0 && cs_n == 1'b0) cs_at = i;
            if (spi_wr) wr_at = i;
            else @(negedge clk);
        end
        chk({tag, "_cs_fall"}, cs_at, 2);
        chk({tag, "_wr_latency"}, wr_at, CS_SETUP + 2);
        chk({tag, "_spi_din"}, spi_din, w);
        chk({tag, "_spi_bits"}, 32'(spi_bits), 32'(cfg_bits));
        chk({tag, "_spi_div"}, 32'(spi_div), 32'(cfg_div));
    endtask

    initial begin
        int w0, c0, n, h, nw;
        repeat (2) @(negedge clk);
        chk("rst_cs_n", 32'(cs_n), 1);
        chk("rst_spi_wr", 32'(spi_wr), 0);
        chk("rst_spi_din", spi_din, 0);
        chk("rst_spi_bits", 32'(spi_bits), 1);
        chk("rst_spi_div", 32'(spi_div), 0);
        chk("rst_tx_full", 32'(tx_full), 0);
        chk("rst_rx_empty", 32'(rx_empty), 1);
        chk("rst_rx_data", rx_data, 0);
        chk("rst_seq_busy", 32'(seq_busy), 0);
`ifdef SPI_RX_OVERRUN_EN
        chk("rst_rx_overrun", 32'(rx_overrun), 0);
`endif
        resetb = 1'b1;
        @(negedge clk);

        // single word with a forced 0x3C reply
        cfg_bits = 6'd8;
        cfg_div  = 8'd1;
        use_ovr  = 1'b1;
        ovr_val  = 32'h3C;
        lat_test("single", 32'hA5);
        pulse_frame_end();
        n = 0;
        while (rx_empty && n < 400) begin
            @(negedge clk);
            n++;
        end
        h = 0;
        while (!cs_n && h < 400) begin
            @(negedge clk);
            h++;
        end
        chk("single_hold", h, CS_HOLD);
        chk("single_seq_busy", 32'(seq_busy), 0);
        pop_check("single_rx");
        chk("single_rx_empty", 32'(rx_empty), 1);

        // three-word burst in one frame
        use_ovr = 1'b0;
        #1;
        w0 = wr_count;
        c0 = cs_rise;
        push(32'h11, 1'b1);
        push(32'h22, 1'b1);
        push(32'h33, 1'b1);
        wait_cs(1'b0, "burst_cs_low");
        pulse_frame_end();
        wait_cs(1'b1, "burst_cs_high");
        #1;
        chk("burst_wr_count", wr_count - w0, 3);
        chk("burst_cs_rises", cs_rise - c0, 1);
        for (int i = 0; i < 3; i++) pop_check($sformatf("burst_rx_%0d", i));

        // 12-bit masking; cfg changed mid-transfer must not affect the word
        use_ovr  = 1'b1;
        ovr_val  = 32'hFFFF_FABC;
        cfg_bits = 6'd12;
        push($urandom, 1'b1);
        wait_cs(1'b0, "w12_cs_low");
        pulse_frame_end();
        n = 0;
        while (!spi_busy && n < 100) begin
            @(negedge clk);
            n++;
        end
        cfg_bits = 6'd4;
        wait_cs(1'b1, "w12_cs_high");
        pop_check("w12_rx");
        use_ovr  = 1'b0;
        cfg_bits = 6'd0;
        push(32'hDEAD_BEEF, 1'b1);
        wait_cs(1'b0, "w32_cs_low");
        pulse_frame_end();
        wait_cs(1'b1, "w32_cs_high");
        pop_check("w32_rx");

        // randomized frames, loopback
        for (int f = 0; f < 5; f++) begin
            nw       = $urandom_range(1, 6);
            cfg_bits = 6'($urandom_range(0, 32));
            cfg_div  = 8'($urandom);
            for (int i = 0; i < nw; i++) push($urandom, 1'b1);
            wait_cs(1'b0, "rnd_cs_low");
            pulse_frame_end();
            wait_cs(1'b1, "rnd_cs_high");
            for (int i = 0; i < nw; i++) pop_check($sformatf("rnd_f%0d_w%0d", f, i));
        end

        cfg_bits = 6'd0;
`ifndef SPI_RX_OVERRUN_EN
        // fill RX, then stall in LAUNCH while TX fills up
        #1;
        w0 = wr_count;
        for (int i = 0; i < 8; i++) push($urandom, 1'b1);
        wait_wr(8, w0);
        repeat (12) @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            push($urandom, i < 8);
            chk($sformatf("txfull_after_%0d", i + 1), 32'(tx_full), 32'(i >= 7));
        end
        repeat (20) @(negedge clk);
        #1;
        chk("stall_wr_count", wr_count - w0, 8);
        chk("stall_cs_low", 32'(cs_n), 0);
        chk("stall_seq_busy", 32'(seq_busy), 1);
        pop_check("stall_first_rx");
        wait_wr(9, w0);
        chk("stall_ninth_wr", wr_count - w0, 9);
        pulse_frame_end();
        while (exp_q.size() > 0) pop_check("stall_rx");
        wait_cs(1'b1, "stall_cs_high");
        #1;
        chk("stall_total_wr", wr_count - w0, 16);
`else
        // overrun: ninth word is transferred but dropped
        #1;
        w0 = wr_count;
        for (int i = 0; i < 9; i++) push($urandom, i < 8);
        wait_wr(9, w0);
        repeat (12) @(negedge clk);
        #1;
        chk("ovr_wr_count", wr_count - w0, 9);
        chk("ovr_flag_set", 32'(rx_overrun), 1);
        ovr_clr = 1'b1;
        @(negedge clk);
        ovr_clr = 1'b0;
        chk("ovr_flag_clr", 32'(rx_overrun), 0);
        pulse_frame_end();
        while (exp_q.size() > 0) pop_check("ovr_rx");
        wait_cs(1'b1, "ovr_cs_high");
        chk("ovr_rx_empty", 32'(rx_empty), 1);
`endif

        // reset during WAIT: cs_n releases asynchronously, queued words vanish
        cfg_bits = 6'd8;
        push(32'h77, 1'b0);
        push(32'h88, 1'b0);
        n = 0;
        while (!spi_busy && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("rst_mid_busy_seen", 32'(spi_busy), 1);
        #2 resetb = 1'b0;
        #1;
        chk("rst_mid_cs_n", 32'(cs_n), 1);
        chk("rst_mid_rx_empty", 32'(rx_empty), 1);
        chk("rst_mid_tx_full", 32'(tx_full), 0);
        chk("rst_mid_seq_busy", 32'(seq_busy), 0);
        @(negedge clk);
        resetb = 1'b1;
        repeat (10) @(negedge clk);
        lat_test("restart", 32'h5A);
        pulse_frame_end();
        wait_cs(1'b1, "restart_cs_high");
        pop_check("restart_rx");
        chk("restart_rx_empty", 32'(rx_empty), 1);

        #1;
        chk("wr_while_cs_high", wr_bad, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
